// File: rtl/lfm_pkg.sv
// Shared definitions for the LFM chirp frequency-word generator:
// mode bit positions, FSM encoding, accumulator controls and width defaults.
package lfm_pkg;

  localparam int FREQ_W_DEF = 48;
  localparam int TIME_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam int MODE_TRI  = 0;
  localparam int MODE_TRIG = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_SWEEP_UP  = 3'd2,
    ST_SWEEP_DN  = 3'd3,
    ST_DWELL     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ACC_HOLD = 2'd0,
    ACC_LOAD = 2'd1,
    ACC_ADD  = 2'd2,
    ACC_SUB  = 2'd3
  } acc_op_e;

endpackage

// File: rtl/lfm_accum.sv
// Frequency-word accumulator: load, add rate, subtract rate or hold.
// Arithmetic wraps modulo 2^FREQ_W.
module lfm_accum
  import lfm_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  acc_op_e           op,
  input  logic [FREQ_W-1:0] load_val,
  input  logic [FREQ_W-1:0] rate,
  output logic [FREQ_W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else begin
      case (op)
        ACC_LOAD: value <= load_val;
        ACC_ADD:  value <= value + rate;
        ACC_SUB:  value <= value - rate;
        default:  value <= value;
      endcase
    end
  end

endmodule

// File: rtl/lfm_sweep_gen.sv
// LFM chirp frequency-word generator: saw/triangle sweeps with trigger, dwell,
// finite run count and config shadowing at sweep boundaries. All outputs registered.
module lfm_sweep_gen
  import lfm_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int TIME_W = TIME_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FREQ_W-1:0] cfg_start,
  input  logic [FREQ_W-1:0] cfg_rate,
  input  logic [TIME_W-1:0] cfg_len,
  input  logic [TIME_W-1:0] cfg_dwell,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              enable,
  input  logic              trig,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid,
  output logic              sweep_start,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);

  // Handshake: there is no backpressure; freq_out is a valid NCO word exactly
  // in the cycles where freq_valid is high, and the consumer must take it then.

  state_e            state_q, state_n;
  logic [TIME_W-1:0] step_q, step_n;
  logic [TIME_W-1:0] dwell_q, dwell_n;
  logic [CNT_W-1:0]  rem_q, rem_n;
  logic              inf_q, inf_n;
  logic              final_q, final_n;
  logic [FREQ_W-1:0] sh_start_q, sh_rate_q;
  logic [TIME_W-1:0] sh_len_q, sh_dwell_q;
  logic              sh_tri_q;
  logic              valid_q, sweep_start_q, busy_q, done_q;
  logic              sweep_start_n, done_n;
  logic              go_start, end_sweep, after_sweep, latch_cfg, tri_dn;
  logic [CNT_W-1:0]  rem_use;
  logic              inf_use;
  acc_op_e           op;
  logic [FREQ_W-1:0] load_val;

  // A triangle only has a down leg when there is an interior word to revisit.
  assign tri_dn    = sh_tri_q && (sh_len_q >= TIME_W'(2));
  assign rem_use   = (state_q == ST_IDLE) ? cfg_count : rem_q;
  assign inf_use   = (state_q == ST_IDLE) ? (cfg_count == '0) : inf_q;
  assign latch_cfg = go_start && enable;

  always_comb begin
    state_n       = state_q;
    op            = ACC_HOLD;
    load_val      = sh_start_q;
    step_n        = step_q;
    dwell_n       = dwell_q;
    rem_n         = rem_q;
    inf_n         = inf_q;
    final_n       = final_q;
    sweep_start_n = 1'b0;
    done_n        = 1'b0;
    go_start      = 1'b0;
    end_sweep     = 1'b0;
    after_sweep   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op       = ACC_LOAD;
        load_val = cfg_start;
        if (trig) begin
          rem_n = cfg_count;
          inf_n = (cfg_count == '0);
          if (cfg_mode[MODE_TRIG]) state_n = ST_WAIT_TRIG;
          else                     go_start = 1'b1;
        end
      end
      ST_WAIT_TRIG: begin
        if (trig) go_start = 1'b1;
      end
      // done is raised together with the final word, so it is looked ahead one step.
      ST_SWEEP_UP: begin
        if (step_q != sh_len_q) begin
          op     = ACC_ADD;
          step_n = step_q + TIME_W'(1);
          if ((step_n == sh_len_q) && !tri_dn) done_n = final_q;
        end else if (tri_dn) begin
          state_n = ST_SWEEP_DN;
          op      = ACC_SUB;
          step_n  = sh_len_q - TIME_W'(1);
          if (sh_len_q == TIME_W'(2)) done_n = final_q;
        end else begin
          end_sweep = 1'b1;
        end
      end
      ST_SWEEP_DN: begin
        if (step_q > TIME_W'(1)) begin
          op     = ACC_SUB;
          step_n = step_q - TIME_W'(1);
          if (step_q == TIME_W'(2)) done_n = final_q;
        end else begin
          end_sweep = 1'b1;
        end
      end
      ST_DWELL: begin
        if (dwell_q <= TIME_W'(1)) after_sweep = 1'b1;
        else                       dwell_n = dwell_q - TIME_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    if (end_sweep) begin
      if (final_q) begin
        state_n  = ST_IDLE;
        op       = ACC_LOAD;
        load_val = cfg_start;
      end else if (sh_dwell_q != '0) begin
        state_n  = ST_DWELL;
        dwell_n  = sh_dwell_q;
        op       = ACC_LOAD;
        load_val = sh_start_q;
      end else begin
        after_sweep = 1'b1;
      end
    end

    if (after_sweep) begin
      if (cfg_mode[MODE_TRIG]) begin
        state_n  = ST_WAIT_TRIG;
        op       = ACC_LOAD;
        load_val = sh_start_q;
      end else begin
        go_start = 1'b1;
      end
    end

    // Remaining counts sweeps not yet started, so the final sweep is known up front.
    if (go_start) begin
      state_n       = ST_SWEEP_UP;
      op            = ACC_LOAD;
      load_val      = cfg_start;
      step_n        = '0;
      sweep_start_n = 1'b1;
      if (!inf_use) rem_n = rem_use - CNT_W'(1);
      final_n = !inf_use && (rem_use == CNT_W'(1));
      done_n  = final_n && (cfg_len == '0);
    end

    if (!enable) begin
      state_n       = ST_IDLE;
      op            = ACC_LOAD;
      load_val      = cfg_start;
      step_n        = '0;
      dwell_n       = '0;
      rem_n         = '0;
      inf_n         = 1'b0;
      final_n       = 1'b0;
      sweep_start_n = 1'b0;
      done_n        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      dwell_q       <= '0;
      rem_q         <= '0;
      inf_q         <= 1'b0;
      final_q       <= 1'b0;
      valid_q       <= 1'b0;
      sweep_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_n;
      step_q        <= step_n;
      dwell_q       <= dwell_n;
      rem_q         <= rem_n;
      inf_q         <= inf_n;
      final_q       <= final_n;
      valid_q       <= (state_n == ST_SWEEP_UP) || (state_n == ST_SWEEP_DN);
      sweep_start_q <= sweep_start_n;
      busy_q        <= (state_n != ST_IDLE);
      done_q        <= done_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_start_q <= '0;
      sh_rate_q  <= '0;
      sh_len_q   <= '0;
      sh_dwell_q <= '0;
      sh_tri_q   <= 1'b0;
    end else if (latch_cfg) begin
      sh_start_q <= cfg_start;
      sh_rate_q  <= cfg_rate;
      sh_len_q   <= cfg_len;
      sh_dwell_q <= cfg_dwell;
      sh_tri_q   <= cfg_mode[MODE_TRI];
    end
  end

  lfm_accum #(.FREQ_W(FREQ_W)) u_accum (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .load_val (load_val),
    .rate     (sh_rate_q),
    .value    (freq_out)
  );

  assign freq_valid  = valid_q;
  assign sweep_start = sweep_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
